supercar_scanner: RTL and testbench

Step-driven "supercar" LED scanner: a lit head LED with an optional trail moves one position per step strobe across an `N_LEDS` bar, bouncing between the ends or wrapping around. It is the consumer end of the prescaler's `p_e` strobe interface. It sits between the team's prescaler and the board LED pins, so the prescaler alone sets the scan speed.

---
 rtl/supercar_pkg.sv | 17 +
 rtl/supercar_scanner.sv | 137 +++++++++++++
 tb/tb_supercar_scanner.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/supercar_pkg.sv
// rtl/supercar_pkg.sv - shared state encoding and mode/direction constants for the LED scanner
package supercar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        DWELL_HI,
        MOVE_DN,
        DWELL_LO
    } state_t;

    localparam logic MODE_BOUNCE = 1'b0;
    localparam logic MODE_WRAP   = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DN      = 1'b1;

endpackage

// File: rtl/supercar_scanner.sv
// rtl/supercar_scanner.sv - step-driven bounce/wrap LED scanner with trail and end dwell
module supercar_scanner
    import supercar_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int TRAIL  = 2,
    parameter int DWELL  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      p_e,
    input  logic                      mode,
    output logic [N_LEDS-1:0]         leds,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      dir,
    output logic                      end_p
);

    localparam int PW = $clog2(N_LEDS);
    localparam int CW = ($clog2(DWELL + 1) > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

    state_t        state;
    logic          cur_mode;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pos_inc;
    logic [PW-1:0] pos_dec;

    // Head plus TRAIL bits behind it; wrap folds indices, bounce clips them.
    function automatic logic [N_LEDS-1:0] trail_mask(input logic [PW-1:0] p,
                                                     input logic d,
                                                     input logic m);
        logic [N_LEDS-1:0] mk;
        int idx;
        mk = '0;
        for (int k = 0; k <= TRAIL; k++) begin
            idx = (d == DIR_UP) ? int'(p) - k : int'(p) + k;
            if (m == MODE_WRAP)
                idx = (idx + N_LEDS) % N_LEDS;
            if (idx >= 0 && idx < N_LEDS)
                mk[idx[PW-1:0]] = 1'b1;
        end
        return mk;
    endfunction

    always_comb begin
        pos_inc = pos + PW'(1);
        pos_dec = pos - PW'(1);
    end

    always_ff @(posedge clk) begin
        end_p <= 1'b0;
        if (!rst) begin
            state    <= IDLE;
            pos      <= '0;
            dir      <= DIR_UP;
            leds     <= '0;
            cnt      <= '0;
            cur_mode <= MODE_BOUNCE;
        end else if (en) begin
            case (state)
                IDLE: begin
                    state    <= MOVE_UP;
                    pos      <= '0;
                    dir      <= DIR_UP;
                    cnt      <= '0;
                    cur_mode <= mode;
                    leds     <= trail_mask('0, DIR_UP, mode);
                end
                MOVE_UP: if (p_e) begin
                    // Only reachable at LAST while wrapping.
                    if (pos == LAST) begin
                        pos  <= '0;
                        leds <= trail_mask('0, DIR_UP, cur_mode);
                    end else begin
                        pos  <= pos_inc;
                        leds <= trail_mask(pos_inc, DIR_UP, cur_mode);
                        if (pos_inc == LAST) begin
                            end_p    <= 1'b1;
                            cur_mode <= mode;
                            if (mode == MODE_BOUNCE) begin
                                cnt <= '0;
                                if (DWELL == 0) begin
                                    state <= MOVE_DN;
                                    dir   <= DIR_DN;
                                end else begin
                                    state <= DWELL_HI;
                                end
                            end
                        end
                    end
                end
                DWELL_HI: if (p_e) begin
                    if (int'(cnt) + 1 >= DWELL) begin
                        state <= MOVE_DN;
                        dir   <= DIR_DN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MOVE_DN: if (p_e) begin
                    if (pos == '0) begin
                        pos  <= LAST;
                        leds <= trail_mask(LAST, DIR_DN, cur_mode);
                    end else begin
                        pos  <= pos_dec;
                        leds <= trail_mask(pos_dec, DIR_DN, cur_mode);
                        if (pos_dec == '0) begin
                            end_p    <= 1'b1;
                            cur_mode <= mode;
                            if (mode == MODE_BOUNCE) begin
                                cnt <= '0;
                                if (DWELL == 0) begin
                                    state <= MOVE_UP;
                                    dir   <= DIR_UP;
                                end else begin
                                    state <= DWELL_LO;
                                end
                            end
                        end
                    end
                end
                DWELL_LO: if (p_e) begin
                    if (int'(cnt) + 1 >= DWELL) begin
                        state <= MOVE_UP;
                        dir   <= DIR_UP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_supercar_scanner.sv
// tb/tb_supercar_scanner.sv - directed and random checks of two scanner configurations against a reference model
module tb_supercar_scanner;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       p_e = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] leds0, leds1;
    logic [2:0] pos0, pos1;
    logic       dir0, dir1, end_p0, end_p1;

    int n_assert = 0;
    int n_fail = 0;
    int ep0 = 0;
    int ep1 = 0;

    int       trl[2] = '{0, 2};
    int       dwl[2] = '{0, 2};
    bit       m_act[2];
    int       m_pos[2];
    bit       m_up[2];
    int       m_hold[2];
    bit       m_mode[2];
    bit       m_ep[2];
    bit [7:0] m_leds[2];

    always #5 clk = ~clk;

    supercar_scanner #(.N_LEDS(8), .TRAIL(0), .DWELL(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .p_e(p_e), .mode(mode),
        .leds(leds0), .pos(pos0), .dir(dir0), .end_p(end_p0)
    );

    supercar_scanner #(.N_LEDS(8), .TRAIL(2), .DWELL(2)) u1 (
        .clk(clk), .rst(rst), .en(en), .p_e(p_e), .mode(mode),
        .leds(leds1), .pos(pos1), .dir(dir1), .end_p(end_p1)
    );

    function automatic bit [7:0] mmask(input int p, input bit up, input bit wrap, input int tr);
        bit [7:0] mk = '0;
        int idx;
        for (int k = 0; k <= tr; k++) begin
            idx = up ? p - k : p + k;
            if (wrap) idx = (idx + N) % N;
            if (idx >= 0 && idx < N) mk[idx] = 1'b1;
        end
        return mk;
    endfunction

    task automatic model_step(input int i);
        m_ep[i] = 0;
        if (!rst) begin
            m_act[i] = 0; m_pos[i] = 0; m_up[i] = 1; m_hold[i] = 0;
            m_mode[i] = 0; m_leds[i] = '0;
        end else if (en) begin
            if (!m_act[i]) begin
                m_act[i] = 1; m_pos[i] = 0; m_up[i] = 1; m_hold[i] = 0;
                m_mode[i] = mode;
                m_leds[i] = mmask(0, 1'b1, mode, trl[i]);
            end else if (p_e) begin
                if (m_hold[i] > 0) begin
                    m_hold[i]--;
                    if (m_hold[i] == 0) m_up[i] = !m_up[i];
                end else begin
                    m_pos[i] = (m_pos[i] + (m_up[i] ? 1 : N - 1)) % N;
                    m_leds[i] = mmask(m_pos[i], m_up[i], m_mode[i], trl[i]);
                    if ((m_up[i] && m_pos[i] == N - 1) || (!m_up[i] && m_pos[i] == 0)) begin
                        m_ep[i] = 1;
                        m_mode[i] = mode;
                        if (!mode) begin
                            m_hold[i] = dwl[i];
                            if (m_hold[i] == 0) m_up[i] = !m_up[i];
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("u0.leds", 32'(leds0), 32'(m_leds[0]));
        chk("u0.pos", 32'(pos0), 32'(m_pos[0]));
        chk("u0.dir", 32'(dir0), m_up[0] ? 32'd0 : 32'd1);
        chk("u0.end_p", 32'(end_p0), 32'(m_ep[0]));
        chk("u1.leds", 32'(leds1), 32'(m_leds[1]));
        chk("u1.pos", 32'(pos1), 32'(m_pos[1]));
        chk("u1.dir", 32'(dir1), m_up[1] ? 32'd0 : 32'd1);
        chk("u1.end_p", 32'(end_p1), 32'(m_ep[1]));
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        if (end_p0 === 1'b1) ep0++;
        if (end_p1 === 1'b1) ep1++;
        check_all();
    endtask

    task automatic step();
        p_e = 1'b1;
        tick();
        p_e = 1'b0;
    endtask

    initial begin
        int e;

        // Reset held for two cycles
        tick(); tick();
        chk("rst.leds", 32'(leds0), 32'h0);
        chk("rst.pos", 32'(pos0), 32'h0);
        chk("rst.dir", 32'(dir0), 32'h0);
        chk("rst.end_p", 32'(end_p1), 32'h0);

        // Bounce sweep; u1 shows trail and dwell on the same stimulus
        rst = 1'b1; en = 1'b1;
        tick();
        chk("load.u0", 32'(leds0), 32'h01);
        chk("load.u1_clip", 32'(leds1), 32'h01);
        ep0 = 0; ep1 = 0;
        for (int s = 1; s <= 15; s++) begin
            repeat (4) tick();
            step();
            e = (s <= 7) ? (1 << s) : (s <= 14) ? (1 << (14 - s)) : 2;
            chk("sweep.u0", 32'(leds0), 32'(e));
            if (s == 5) chk("trail.up5", 32'(leds1), 32'h38);
            if (s >= 7 && s <= 9) chk("dwell.hold", 32'(pos1), 32'd7);
            if (s == 10) chk("dwell.leave", 32'(pos1), 32'd6);
            if (s == 14) chk("trail.dn2", 32'(leds1), 32'h1C);
        end
        chk("sweep.ep0", 32'(ep0), 32'd2);
        chk("sweep.ep1", 32'(ep1), 32'd1);

        // Reset in the middle of a scan
        repeat (4) begin tick(); step(); end
        chk("mid.pos5", 32'(pos0), 32'd5);
        rst = 1'b0;
        tick();
        rst = 1'b1; en = 1'b0;
        chk("mid.leds", 32'(leds0), 32'h0);
        tick();
        chk("mid.idle", 32'(leds0), 32'h0);

        // Freeze with strobes still arriving
        en = 1'b1;
        tick();
        repeat (3) begin tick(); step(); end
        chk("frz.pos3", 32'(pos0), 32'd3);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            p_e = i[0];
            tick();
            chk("frz.pos", 32'(pos0), 32'd3);
            chk("frz.leds", 32'(leds0), 32'h08);
        end
        p_e = 1'b0;
        en = 1'b1;
        step();
        chk("frz.resume", 32'(pos0), 32'd4);

        // Wrap with trail
        rst = 1'b0;
        tick();
        rst = 1'b1; mode = 1'b1;
        tick();
        for (int s = 1; s <= 8; s++) begin
            tick();
            step();
            chk("wrap.dir", 32'(dir1), 32'd0);
        end
        chk("wrap.pos0", 32'(pos1), 32'd0);
        chk("wrap.leds", 32'(leds1), 32'hC1);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) != 0);
            en = ($urandom_range(0, 9) != 0);
            p_e = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
